// File: rtl/fifo_prefetch_fwft.sv
// First-word-fall-through adapter in front of a standard-read FIFO with configurable read latency.
// Optional macro FIFO_PREFETCH_ERR_EN adds a sticky Underrun output.
module fifo_prefetch_fwft #(
    parameter int DataWidth      = 8,
    parameter int DataCountWidth = 3,
    parameter int ReadLatency    = 1,
    parameter int PrefetchDepth  = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Empty,
    input  logic [DataWidth-1:0]      RdData,
    input  logic [DataCountWidth-1:0] DataCountIn,
    output logic                      Read,
    input  logic                      Unload,
    output logic                      Valid,
    output logic [DataWidth-1:0]      Data,
`ifdef FIFO_PREFETCH_ERR_EN
    output logic                      Underrun,
`endif
    output logic [DataCountWidth-1:0] DataCountOut
);

    localparam int PtrWidth = (PrefetchDepth > 1) ? $clog2(PrefetchDepth) : 1;
    localparam int CntWidth = $clog2(PrefetchDepth + 1);

    logic [DataWidth-1:0]   buffer [PrefetchDepth];
    logic [PtrWidth-1:0]    wr_ptr;
    logic [PtrWidth-1:0]    rd_ptr;
    logic [CntWidth-1:0]    occ;
    logic [CntWidth-1:0]    in_flight_cnt;
    logic [ReadLatency-1:0] in_flight;
    logic                   pop;
    logic                   land;
    int                     credit;

    // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(PrefetchDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign pop   = Unload & Valid;
    assign land  = in_flight[ReadLatency-1];
    assign Valid = (occ != '0);
    assign Data  = buffer[rd_ptr];

    always_comb begin
        in_flight_cnt = '0;
        for (int i = 0; i < ReadLatency; i++) begin
            in_flight_cnt = in_flight_cnt + CntWidth'(in_flight[i]);
        end
    end

    // A same-cycle pop frees its slot, so a steady pop stream keeps reads continuous.
    always_comb begin
        credit = int'(occ) + int'(in_flight_cnt) - int'(pop);
        Read   = ~Reset & ~Empty & (credit < PrefetchDepth);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            in_flight <= '0;
        end else begin
            in_flight <= (in_flight << 1) | ReadLatency'(Read);
            if (land) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            occ <= occ + CntWidth'(land) - CntWidth'(pop);
        end
    end

    // NOTE: storage is not reset; occ gates its visibility, which keeps it plain RAM/flops.
    always_ff @(posedge Clk) begin
        if (land && !Reset) begin
            buffer[wr_ptr] <= RdData;
        end
    end

    assign DataCountOut = DataCountIn + DataCountWidth'(occ) + DataCountWidth'(in_flight_cnt);

`ifdef FIFO_PREFETCH_ERR_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Underrun <= 1'b0;
        end else if (Unload && !Valid) begin
            Underrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_prefetch_fwft.sv
// Randomised bench for fifo_prefetch_fwft with an upstream FIFO model and a word-level reference.
// Build with FIFO_PREFETCH_ERR_EN to also check the Underrun flag.
module tb_fifo_prefetch_fwft;

    localparam int DW  = 8;
    localparam int DCW = 4;
    localparam int RL  = 2;
    localparam int D   = 3;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Empty;
    logic [DW-1:0]  RdData;
    logic [DCW-1:0] DataCountIn;
    logic           Read;
    logic           Unload;
    logic           Valid;
    logic [DW-1:0]  Data;
    logic [DCW-1:0] DataCountOut;
`ifdef FIFO_PREFETCH_ERR_EN
    logic           Underrun;
`endif

    fifo_prefetch_fwft #(
        .DataWidth(DW), .DataCountWidth(DCW), .ReadLatency(RL), .PrefetchDepth(D)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Empty(Empty), .RdData(RdData),
        .DataCountIn(DataCountIn), .Read(Read), .Unload(Unload),
        .Valid(Valid), .Data(Data),
`ifdef FIFO_PREFETCH_ERR_EN
        .Underrun(Underrun),
`endif
        .DataCountOut(DataCountOut)
    );

    always #5 Clk = ~Clk;

    // Upstream FIFO contents, words taken but not yet consumed, and the read-latency pipe.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pipe[RL];
    int            read_cyc[$];
    int            avail;
    int            cyc;
    logic          last_read;
    logic [DW-1:0] last_word;
    logic          und_exp;

    int   n_vec;
    int   n_err;
    int   obs_reads;
    int   obs_pops;
    int   obs_valids;
    logic obs_v;

    // One clock of stimulus plus per-cycle comparison against the word-level reference.
    task automatic cycle(input logic unl, input logic rst);
        logic exp_valid;
        logic exp_read;
        logic pop;
        @(negedge Clk);
        cyc++;
        for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]     = last_read ? last_word : DW'($urandom);
        RdData      = pipe[RL-1];
        Empty       = (fifo_q.size() == 0);
        DataCountIn = DCW'(fifo_q.size());
        Unload      = unl;
        Reset       = rst;
        // A word read in cycle c is visible at the output from cycle c+RL+1.
        while (read_cyc.size() != 0 && read_cyc[0] + RL + 1 <= cyc) begin
            avail++;
            void'(read_cyc.pop_front());
        end
        #1;
        exp_valid = (avail > 0);
        pop       = unl && exp_valid && !rst;
        exp_read  = !rst && (fifo_q.size() != 0) && (exp_q.size() - int'(pop) < D);

        n_vec++;
        if (Read !== exp_read) begin
            n_err++;
            $display("FAIL read cyc=%0d: got %b expected %b", cyc, Read, exp_read);
        end
        if (!rst) begin
            n_vec++;
            if (Valid !== exp_valid) begin
                n_err++;
                $display("FAIL valid cyc=%0d: got %b expected %b", cyc, Valid, exp_valid);
            end
            if (exp_valid) begin
                n_vec++;
                if (Data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL data cyc=%0d: got %h expected %h", cyc, Data, exp_q[0]);
                end
            end
            n_vec++;
            if (DataCountOut !== DCW'(fifo_q.size() + exp_q.size())) begin
                n_err++;
                $display("FAIL count cyc=%0d: got %0d expected %0d", cyc, DataCountOut,
                         DCW'(fifo_q.size() + exp_q.size()));
            end
`ifdef FIFO_PREFETCH_ERR_EN
            n_vec++;
            if (Underrun !== und_exp) begin
                n_err++;
                $display("FAIL underrun cyc=%0d: got %b expected %b", cyc, Underrun, und_exp);
            end
`endif
        end

        obs_v = (Valid === 1'b1);
        if (Read === 1'b1) obs_reads++;
        if (obs_v) obs_valids++;
        if (obs_v && unl) obs_pops++;

        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            read_cyc.delete();
            avail     = 0;
            last_read = 1'b0;
            und_exp   = 1'b0;
        end else begin
            if (unl && !exp_valid) und_exp = 1'b1;
            if (pop) begin
                void'(exp_q.pop_front());
                avail--;
            end
            last_read = exp_read;
            if (exp_read) begin
                last_word = fifo_q.pop_front();
                exp_q.push_back(last_word);
                read_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
            cycle(1'b1, 1'b0);
            n++;
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic test_latency();
        int base  = obs_reads;
        int first = -1;
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0);
            if (obs_v && first < 0) first = i;
        end
        n_vec++;
        if (obs_reads - base !== 3) begin
            n_err++;
            $display("FAIL latency_reads: got %0d expected 3", obs_reads - base);
        end
        n_vec++;
        if (first !== RL + 1) begin
            n_err++;
            $display("FAIL latency_first_valid: got %0d expected %0d", first, RL + 1);
        end
    endtask

    task automatic test_stream();
        int base  = obs_reads;
        int first = -1;
        int last  = -1;
        int vcnt  = 0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            if (obs_v) begin
                if (first < 0) first = i;
                last = i;
                vcnt++;
            end
        end
        n_vec++;
        if (vcnt !== 3 || last - first !== 2) begin
            n_err++;
            $display("FAIL stream_no_bubble: got %0d valid cycles span %0d expected 3 span 2",
                     vcnt, last - first);
        end
        n_vec++;
        if (obs_reads - base !== 3) begin
            n_err++;
            $display("FAIL stream_reads: got %0d expected 3", obs_reads - base);
        end
    endtask

    task automatic test_alternate();
        int base = obs_pops;
        int n    = 0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
            cycle(n[0] == 1'b0, 1'b0);
            n++;
        end
        n_vec++;
        if (obs_pops - base !== 8) begin
            n_err++;
            $display("FAIL alternate_pops: got %0d expected 8", obs_pops - base);
        end
    endtask

    task automatic test_empty_unload();
        int rbase = obs_reads;
        int vbase = obs_valids;
        for (int i = 0; i < 6; i++) cycle((i % 2 == 0) || i == 5, 1'b0);
        cycle(1'b0, 1'b0);
        n_vec++;
        if (obs_reads - rbase !== 0 || obs_valids - vbase !== 0) begin
            n_err++;
            $display("FAIL empty_unload: got reads %0d valids %0d expected 0 0",
                     obs_reads - rbase, obs_valids - vbase);
        end
`ifdef FIFO_PREFETCH_ERR_EN
        n_vec++;
        if (Underrun !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_sticky: got %b expected 1", Underrun);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int rbase;
        int vbase;
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        rbase = obs_reads;
        vbase = obs_valids;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        n_vec++;
        if (obs_reads - rbase !== 0 || obs_valids - vbase !== 0) begin
            n_err++;
            $display("FAIL reset_mid: got reads %0d valids %0d expected 0 0",
                     obs_reads - rbase, obs_valids - vbase);
        end
    endtask

    task automatic test_random();
        int base   = obs_pops;
        int pushed = 0;
        for (int i = 0; i < 300; i++) begin
            if (fifo_q.size() < 10 && $urandom_range(0, 2) == 0) begin
                fifo_q.push_back(DW'($urandom));
                pushed++;
            end
            cycle(1'($urandom_range(0, 1)), 1'b0);
        end
        drain();
        n_vec++;
        if (obs_pops - base !== pushed) begin
            n_err++;
            $display("FAIL random_pops: got %0d expected %0d", obs_pops - base, pushed);
        end
    endtask

    initial begin
        Reset       = 1'b1;
        Empty       = 1'b1;
        Unload      = 1'b0;
        RdData      = '0;
        DataCountIn = '0;
        for (int i = 0; i < RL; i++) pipe[i] = '0;
        avail      = 0;
        cyc        = 0;
        last_read  = 1'b0;
        last_word  = '0;
        und_exp    = 1'b0;
        n_vec      = 0;
        n_err      = 0;
        obs_reads  = 0;
        obs_pops   = 0;
        obs_valids = 0;
        obs_v      = 1'b0;

        test_reset();
        test_latency();
        drain();
        test_stream();
        drain();
        test_alternate();
        test_empty_unload();
        test_reset_mid();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
